// File: rtl/rhd_spi_frame_master_if.sv
// Bus bundle for rhd_spi_frame_master: command handshake, SPI pins, MISO lines and capture vectors.
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready; cmd is sampled only then.
interface rhd_spi_frame_master_if;
  logic [15:0] cmd;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cs_n;
  logic        sclk;
  logic        mosi;
  logic        miso1;
  logic        miso2;
  logic [73:0] miso4x_1;
  logic [73:0] miso4x_2;
  logic        miso4x_valid;
  logic        frame_busy;

  modport master (
    output cmd, cmd_valid, miso1, miso2,
    input  cmd_ready, cs_n, sclk, mosi, miso4x_1, miso4x_2, miso4x_valid, frame_busy
  );

  modport slave (
    input  cmd, cmd_valid, miso1, miso2,
    output cmd_ready, cs_n, sclk, mosi, miso4x_1, miso4x_2, miso4x_valid, frame_busy
  );
endinterface

// File: rtl/rhd_spi_frame_master.sv
// RHD2000 SPI frame master: one 16-bit MOSI command per frame plus 4x-oversampled MISO capture.
// Optional SPI_MISO_SYNC_EN adds a 2-flop synchronizer ahead of the MISO input register.
module rhd_spi_frame_master #(
  parameter int FRAME_TICKS = 80
) (
  input logic                    dataclk,
  input logic                    reset,
  rhd_spi_frame_master_if.slave  bus
);
  localparam logic [7:0] LAST_TICK = 8'(FRAME_TICKS - 1);

  typedef enum logic {IDLE = 1'b0, FRAME = 1'b1} state_t;

  state_t      state;
  state_t      next_state;
  logic [7:0]  tick;
  logic [7:0]  next_tick;
  logic [15:0] cmd_q;
  logic [15:0] next_cmd;
  logic [3:0]  bit_idx;
  logic        next_win;
  logic        accept;
  logic        miso1_r;
  logic        miso2_r;
  logic [73:0] shift_1;
  logic [73:0] shift_2;

`ifdef SPI_MISO_SYNC_EN
  logic [1:0] sync_1;
  logic [1:0] sync_2;

  always_ff @(posedge dataclk) begin
    sync_1  <= {sync_1[0], bus.miso1};
    sync_2  <= {sync_2[0], bus.miso2};
    miso1_r <= sync_1[1];
    miso2_r <= sync_2[1];
  end
`else
  always_ff @(posedge dataclk) begin
    miso1_r <= bus.miso1;
    miso2_r <= bus.miso2;
  end
`endif

  // Outputs are registered from the next tick so pin values for tick t show while tick==t.
  always_comb begin
    accept     = bus.cmd_valid && bus.cmd_ready;
    next_state = state;
    next_tick  = tick;
    next_cmd   = cmd_q;
    if (accept) begin
      next_state = FRAME;
      next_tick  = 8'd0;
      next_cmd   = bus.cmd;
    end else if (state == FRAME) begin
      if (tick == LAST_TICK) next_state = IDLE;
      else                   next_tick  = tick + 8'd1;
    end
    bit_idx  = 4'((next_tick - 8'd4) >> 2);
    next_win = (next_state == FRAME) && (next_tick >= 8'd4) && (next_tick < 8'd68);
  end

  always_ff @(posedge dataclk) begin
    if (reset) begin
      state            <= IDLE;
      tick             <= 8'd0;
      cmd_q            <= 16'd0;
      bus.cs_n         <= 1'b1;
      bus.sclk         <= 1'b0;
      bus.mosi         <= 1'b0;
      bus.cmd_ready    <= 1'b1;
      bus.frame_busy   <= 1'b0;
      bus.miso4x_1     <= '0;
      bus.miso4x_2     <= '0;
      bus.miso4x_valid <= 1'b0;
      shift_1          <= '0;
      shift_2          <= '0;
    end else begin
      state          <= next_state;
      tick           <= next_tick;
      cmd_q          <= next_cmd;
      bus.cs_n       <= !((next_state == FRAME) && (next_tick < 8'd68));
      bus.sclk       <= next_win && next_tick[1];
      bus.mosi       <= next_win && next_cmd[4'd15 - bit_idx];
      bus.cmd_ready  <= (next_state == IDLE) || (next_tick == LAST_TICK);
      bus.frame_busy <= (next_state == FRAME);
      bus.miso4x_valid <= 1'b0;
      // Shift in MSB-side so the first sample (tick 4) ends at index 0 after 74 shifts.
      if (state == FRAME && tick >= 8'd4 && tick <= 8'd77) begin
        shift_1 <= {miso1_r, shift_1[73:1]};
        shift_2 <= {miso2_r, shift_2[73:1]};
      end
      // Publishing on the last shift lands the pulse on tick 78, or on the next frame's tick 0 when FRAME_TICKS=78.
      if (state == FRAME && tick == 8'd77) begin
        bus.miso4x_1     <= {miso1_r, shift_1[73:1]};
        bus.miso4x_2     <= {miso2_r, shift_2[73:1]};
        bus.miso4x_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_rhd_spi_frame_master.sv
// Self-checking bench for rhd_spi_frame_master: frame-level reference model plus directed literal checks.
module tb_rhd_spi_frame_master;
  localparam int FT = 80;
`ifdef SPI_MISO_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic dataclk = 1'b0;
  logic reset   = 1'b1;
  rhd_spi_frame_master_if bus();

  rhd_spi_frame_master #(.FRAME_TICKS(FT)) dut (
    .dataclk (dataclk),
    .reset   (reset),
    .bus     (bus)
  );

  // clock / reset
  always #5 dataclk = ~dataclk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [73:0] got, input logic [73:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // reference model: frame position since acceptance, MISO history by cycle
  bit          m_known = 0;
  bit          m_busy  = 0;
  int          m_tick  = 0;
  int          m_start = 0;
  logic [15:0] m_cmd   = '0;
  logic        m_valid = 1'b0;
  logic [73:0] m_vec1  = '0;
  logic [73:0] m_vec2  = '0;
  int          cyc     = 0;
  bit          h1 [0:32767];
  bit          h2 [0:32767];

  function automatic logic [2:0] spi_exp(input bit busy, input int t, input logic [15:0] c);
    if (!busy)  return 3'b100;
    if (t < 4)  return 3'b000;
    if (t >= 68) return 3'b100;
    return {1'b0, (((t - 4) % 4) >= 2) ? 1'b1 : 1'b0, c[15 - (t - 4) / 4]};
  endfunction

  always @(negedge dataclk) begin
    logic [2:0] e;
    bit rdy;
    rdy = !m_busy || (m_tick == FT - 1);
    if (m_known) begin
      e = spi_exp(m_busy, m_tick, m_cmd);
      chk("cs_n",         bus.cs_n,         e[2]);
      chk("sclk",         bus.sclk,         e[1]);
      chk("mosi",         bus.mosi,         e[0]);
      chk("cmd_ready",    bus.cmd_ready,    rdy);
      chk("frame_busy",   bus.frame_busy,   m_busy);
      chk("miso4x_valid", bus.miso4x_valid, m_valid);
      chk("miso4x_1",     bus.miso4x_1,     m_vec1);
      chk("miso4x_2",     bus.miso4x_2,     m_vec2);
    end
    h1[cyc] = bus.miso1;
    h2[cyc] = bus.miso2;
    if (reset) begin
      m_known = 1; m_busy = 0; m_tick = 0; m_valid = 0; m_vec1 = '0; m_vec2 = '0;
    end else if (m_known) begin
      m_valid = m_busy && (m_tick == 77);
      if (m_valid) begin
        // sample for tick 4+k is the line value LAT cycles earlier
        for (int k = 0; k < 74; k++) begin
          m_vec1[k] = h1[m_start + 4 + k - LAT];
          m_vec2[k] = h2[m_start + 4 + k - LAT];
        end
      end
      if (bus.cmd_valid && rdy) begin
        m_busy = 1; m_tick = 0; m_cmd = bus.cmd; m_start = cyc + 1;
      end else if (m_busy) begin
        if (m_tick == FT - 1) m_busy = 0;
        else m_tick++;
      end
    end
    cyc++;
  end

  // driver tasks
  task automatic send(input logic [15:0] c);
    bit ok = 0;
    bus.cmd = c;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge dataclk);
      if (bus.cmd_ready) ok = 1;
      @(posedge dataclk); #1;
    end
    bus.cmd_valid = 1'b0;
    chk("send_accept", ok, 1'b1);
  endtask

  logic [15:0] o_bits;
  int          o_rises, o_first, o_cslow, o_busy, o_vcnt, o_vtick, o_acc;
  logic        o_rcs, o_rsclk, o_rbusy;
  logic [73:0] o_v1, o_v2;

  // Runs n cycles starting at the caller's current cycle (j = 0), collecting pin statistics.
  task automatic observe(input int n, input int mode, input int inj_j, input int rst_j);
    logic prev = 1'b0;
    bit   acc;
    o_bits = '0; o_rises = 0; o_first = -1; o_cslow = 0; o_busy = 0;
    o_vcnt = 0; o_vtick = -1; o_acc = -1; o_v1 = '0; o_v2 = '0;
    for (int j = 0; j < n; j++) begin
      if (mode == 1) begin
        bus.miso1 = (j >= 4 - LAT && j <= 7 - LAT);
        bus.miso2 = 1'b1;
      end else begin
        bus.miso1 = 1'($urandom);
        bus.miso2 = 1'($urandom);
      end
      if (j == inj_j) begin bus.cmd = 16'hFFFF; bus.cmd_valid = 1'b1; end
      if (j == rst_j) reset = 1'b1;
      if (rst_j >= 0 && j == rst_j + 3) reset = 1'b0;
      @(negedge dataclk);
      if (bus.frame_busy) o_busy++;
      if (!bus.cs_n) o_cslow++;
      if (bus.sclk && !prev) begin
        o_bits = {o_bits[14:0], bus.mosi};
        if (o_first < 0) o_first = j;
        o_rises++;
      end
      prev = bus.sclk;
      if (bus.miso4x_valid) begin o_vcnt++; o_vtick = j; o_v1 = bus.miso4x_1; o_v2 = bus.miso4x_2; end
      if (rst_j >= 0 && j == rst_j + 1) begin o_rcs = bus.cs_n; o_rsclk = bus.sclk; o_rbusy = bus.frame_busy; end
      acc = bus.cmd_valid && bus.cmd_ready;
      if (acc && o_acc < 0) o_acc = j;
      @(posedge dataclk); #1;
      if (acc) bus.cmd_valid = 1'b0;
    end
  endtask

  initial begin
    bus.cmd = '0; bus.cmd_valid = 1'b0; bus.miso1 = 1'b0; bus.miso2 = 1'b0;
    // reset held three cycles
    reset = 1'b1;
    repeat (3) @(posedge dataclk);
    #1;
    chk("rst_cs_n",      bus.cs_n,         1'b1);
    chk("rst_sclk",      bus.sclk,         1'b0);
    chk("rst_mosi",      bus.mosi,         1'b0);
    chk("rst_cmd_ready", bus.cmd_ready,    1'b1);
    chk("rst_vec1",      bus.miso4x_1,     74'd0);
    chk("rst_valid",     bus.miso4x_valid, 1'b0);
    reset = 1'b0;
    repeat (2) @(posedge dataclk);
    #1;

    // single frame 16'hA5C3 with a known MISO pattern
    bus.miso1 = 1'b0; bus.miso2 = 1'b1;
    send(16'hA5C3);
    observe(90, 1, -1, -1);
    chk("a5c3_bits",      o_bits,   16'hA5C3);
    chk("a5c3_rises",     o_rises,  16);
    chk("a5c3_first_rise", o_first, 6);
    chk("a5c3_cs_low",    o_cslow,  68);
    chk("a5c3_frame_len", o_busy,   80);
    chk("a5c3_vcnt",      o_vcnt,   1);
    chk("a5c3_vtick",     o_vtick,  78);
    chk("a5c3_vec1",      o_v1,     74'hF);
    chk("a5c3_vec2",      o_v2,     {74{1'b1}});

    // back-to-back with cmd_valid held high
    begin
      logic [15:0] cmds [2];
      int idx = 0, vcnt = 0, run = 0, gap = -1;
      bit seen_low = 0, acc;
      cmds[0] = 16'h0001; cmds[1] = 16'h8000;
      bus.cmd = cmds[0]; bus.cmd_valid = 1'b1;
      for (int j = 0; j < 260; j++) begin
        bus.miso1 = 1'($urandom); bus.miso2 = 1'($urandom);
        @(negedge dataclk);
        if (!bus.cs_n) begin
          if (seen_low && run > 0) gap = run;
          seen_low = 1; run = 0;
        end else if (seen_low) run++;
        if (bus.miso4x_valid) vcnt++;
        acc = bus.cmd_valid && bus.cmd_ready;
        @(posedge dataclk); #1;
        if (acc) begin
          idx++;
          if (idx < 2) bus.cmd = cmds[idx];
          else bus.cmd_valid = 1'b0;
        end
      end
      chk("b2b_accepts", idx,  2);
      chk("b2b_cs_gap",  gap,  12);
      chk("b2b_vcnt",    vcnt, 2);
    end

    // mid-frame command is ignored until the last tick
    send(16'h1234);
    observe(80, 0, 30, -1);
    chk("ign_bits",   o_bits, 16'h1234);
    chk("ign_accept", o_acc,  79);
    observe(84, 0, -1, -1);
    chk("ign_next_bits", o_bits, 16'hFFFF);

    // reset at tick 30 aborts the frame
    send(16'hABCD);
    observe(40, 0, -1, 30);
    chk("rst_mid_cs_n", o_rcs,   1'b1);
    chk("rst_mid_sclk", o_rsclk, 1'b0);
    chk("rst_mid_busy", o_rbusy, 1'b0);
    chk("rst_mid_vcnt", o_vcnt,  0);
    observe(90, 0, -1, -1);
    chk("rst_after_vcnt", o_vcnt, 0);
    send(16'h3C3C);
    observe(82, 0, -1, -1);
    chk("rst_new_bits",  o_bits,  16'h3C3C);
    chk("rst_new_first", o_first, 6);
    chk("rst_new_len",   o_busy,  80);

    // randomized traffic with occasional resets
    for (int i = 0; i < 6000; i++) begin
      bus.miso1 = 1'($urandom);
      bus.miso2 = 1'($urandom);
      bus.cmd = 16'($urandom);
      bus.cmd_valid = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 1499) == 0);
      @(posedge dataclk); #1;
    end
    bus.cmd_valid = 1'b0;
    reset = 1'b0;
    repeat (100) @(posedge dataclk);
    #1;

    // report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
